// File: rtl/battleship_pkg.sv
// Shared types and helpers for the seven-segment scan decoder.
// Holds the digit count, the filter FSM states and the active-low strobe decode.
package battleship_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HOLD
  } state_e;

  // True when exactly one strobe line is low.
  function automatic logic onehot_low_valid(input logic [NUM_DIGITS-1:0] sel);
    return $countones(~sel) == 1;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_low_to_index(input logic [NUM_DIGITS-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Bundle of the multiplexed display inputs and the decoded frame outputs.
interface ssd_scan_decoder_if;
  logic [7:0] seven;
  logic [3:0] segment;
  logic [7:0] disp0;
  logic [7:0] disp1;
  logic [7:0] disp2;
  logic [7:0] disp3;
  logic       frame_valid;
  logic       stale;
  logic [7:0] glitch_cnt;

  modport master (
    output seven, segment,
    input  disp0, disp1, disp2, disp3, frame_valid, stale, glitch_cnt
  );

  modport slave (
    input  seven, segment,
    output disp0, disp1, disp2, disp3, frame_valid, stale, glitch_cnt
  );
endinterface

// File: rtl/ssd_stable_filter.sv
// Debounces the sampled digit strobe/pattern and emits one capture per stable dwell.
module ssd_stable_filter import battleship_pkg::*; #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       pat,
  output logic             capture,
  output logic [IDX_W-1:0] cap_idx,
  output logic [7:0]       cap_pat
);

  localparam int unsigned CW = $clog2(STABLE_CYC + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       pat_q, pat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             same;

  assign same    = (idx == idx_q) && (pat == pat_q);
  assign cap_idx = idx_q;
  assign cap_pat = pat_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!valid) begin
      state_d = S_WAIT;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          state_d = S_SETTLE;
          idx_d   = idx;
          pat_d   = pat;
          cnt_d   = CW'(1);
        end
        S_SETTLE: begin
          if (same) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(STABLE_CYC)) begin
              capture = 1'b1;
              state_d = S_HOLD;
            end
          end else begin
            idx_d = idx;
            pat_d = pat;
            cnt_d = CW'(1);
          end
        end
        S_HOLD: begin
          // Only a change of digit or pattern re-arms a capture.
          if (!same) begin
            state_d = S_SETTLE;
            idx_d   = idx;
            pat_d   = pat;
            cnt_d   = CW'(1);
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_WAIT;
      idx_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Recovers four static digit patterns from a multiplexed seven-segment scan,
// with frame commit, staleness timeout and a saturating glitch counter.
module ssd_scan_decoder import battleship_pkg::*; #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input logic               clk,
  input logic               rst,
  ssd_scan_decoder_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]            seven_q;
  logic [NUM_DIGITS-1:0] seg_q;
  logic                  primed_q;
  logic                  smp_valid, smp_invalid;
  logic                  capture;
  logic [IDX_W-1:0]      cap_idx;
  logic [7:0]            cap_pat;

  logic [7:0]            shadow_q [NUM_DIGITS];
  logic [7:0]            shadow_d [NUM_DIGITS];
  logic [7:0]            disp_q   [NUM_DIGITS];
  logic [7:0]            disp_d   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  fv_q, fv_d;
  logic [7:0]            glitch_q, glitch_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  // primed_q masks the idle reset value so it is never counted as a sample.
  assign smp_valid   = primed_q & onehot_low_valid(seg_q);
  assign smp_invalid = primed_q & ~onehot_low_valid(seg_q);

  ssd_stable_filter #(
    .STABLE_CYC(STABLE_CYC)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .valid  (smp_valid),
    .idx    (onehot_low_to_index(seg_q)),
    .pat    (seven_q),
    .capture(capture),
    .cap_idx(cap_idx),
    .cap_pat(cap_pat)
  );

  always_comb begin
    shadow_d = shadow_q;
    disp_d   = disp_q;
    seen_d   = seen_q;
    fv_d     = 1'b0;
    if (&seen_q) begin
      disp_d = shadow_q;
      fv_d   = 1'b1;
      seen_d = '0;
    end
    if (capture) begin
      shadow_d[cap_idx] = ~cap_pat;
      seen_d[cap_idx]   = 1'b1;
    end
    glitch_d = (smp_invalid && glitch_q != 8'hFF) ? glitch_q + 8'd1 : glitch_q;
    if (capture)                        tmo_d = '0;
    else if (tmo_q == TW'(TIMEOUT_CYC)) tmo_d = tmo_q;
    else                                tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seven_q  <= '1;
      seg_q    <= '1;
      primed_q <= 1'b0;
      shadow_q <= '{default: '0};
      disp_q   <= '{default: '0};
      seen_q   <= '0;
      fv_q     <= 1'b0;
      glitch_q <= '0;
      tmo_q    <= '0;
    end else begin
      seven_q  <= bus.seven;
      seg_q    <= bus.segment;
      primed_q <= 1'b1;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seen_q   <= seen_d;
      fv_q     <= fv_d;
      glitch_q <= glitch_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.disp0       = disp_q[0];
  assign bus.disp1       = disp_q[1];
  assign bus.disp2       = disp_q[2];
  assign bus.disp3       = disp_q[3];
  assign bus.frame_valid = fv_q;
  assign bus.stale       = (tmo_q == TW'(TIMEOUT_CYC));
  assign bus.glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed-vector bench for ssd_scan_decoder with STABLE_CYC=4, TIMEOUT_CYC=64.
module tb_ssd_scan_decoder;
  import battleship_pkg::*;

  localparam int unsigned STABLE_CYC  = 4;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   fv_cnt = 0;
  int   fv0;

  always #5 clk = ~clk;

  ssd_scan_decoder_if bus ();

  ssd_scan_decoder #(
    .STABLE_CYC (STABLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) if (bus.frame_valid) fv_cnt <= fv_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold one strobe/pattern for n cycles; returns #1 after the last edge.
  task automatic step(input logic [3:0] seg, input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      bus.segment = seg;
      bus.seven   = pat;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input int d2_len);
    step(4'b1110, 8'hC0, 8);
    step(4'b1101, 8'hF9, 8);
    step(4'b1011, 8'hA4, d2_len);
    step(4'b0111, 8'hB0, 8);
  endtask

  task automatic do_reset();
    bus.segment = 4'hF;
    bus.seven   = 8'hFF;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_d0"}, bus.disp0, 8'h3F);
    check({tag, "_d1"}, bus.disp1, 8'h06);
    check({tag, "_d2"}, bus.disp2, 8'h5B);
    check({tag, "_d3"}, bus.disp3, 8'h4F);
  endtask

  initial begin
    bus.segment = 4'hF;
    bus.seven   = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp0", bus.disp0, 8'h00);
    check("rst_fv", bus.frame_valid, 1'b0);
    check("rst_stale", bus.stale, 1'b0);
    check("rst_glitch", bus.glitch_cnt, 8'h00);
    rst = 1'b1;

    // Clean scans: one commit per scan.
    fv0 = fv_cnt;
    scan(8);
    check("scan1_fv", fv_cnt - fv0, 1);
    check_frame("scan1");
    scan(8);
    check("scan2_fv", fv_cnt - fv0, 2);
    check("scan_glitch", bus.glitch_cnt, 8'h00);

    // Digit 2 never dwells long enough to be captured.
    do_reset();
    fv0 = fv_cnt;
    scan(3);
    scan(3);
    check("short_fv", fv_cnt - fv0, 0);
    check("short_d2", bus.disp2, 8'h00);

    // Two-zero strobe between digits.
    do_reset();
    fv0 = fv_cnt;
    step(4'b1110, 8'hC0, 8);
    step(4'b1101, 8'hF9, 8);
    step(4'b0011, 8'hFF, 2);
    step(4'b1011, 8'hA4, 8);
    step(4'b0111, 8'hB0, 8);
    check("glitch2_cnt", bus.glitch_cnt, 8'd2);
    check("glitch2_fv", fv_cnt - fv0, 1);
    check_frame("glitch2");

    // Timeout: digit 3 captured on the first idle edge, stale 64 edges later.
    do_reset();
    step(4'b1110, 8'hC0, 8);
    step(4'b1101, 8'hF9, 8);
    step(4'b1011, 8'hA4, 8);
    step(4'b0111, 8'hB0, 4);
    for (int k = 1; k <= 70; k++) begin
      step(4'b1111, 8'hFF, 1);
      if (k == 64) check("stale_pre", bus.stale, 1'b0);
      if (k == 65) check("stale_set", bus.stale, 1'b1);
    end
    check_frame("stale");
    step(4'b1110, 8'hC0, 4);
    check("stale_hold", bus.stale, 1'b1);
    step(4'b1110, 8'hC0, 1);
    check("stale_clr", bus.stale, 1'b0);
    check("idle_glitch", bus.glitch_cnt, 8'd70);

    // Reset mid-frame discards partial shadows.
    do_reset();
    step(4'b1110, 8'hC0, 8);
    step(4'b1101, 8'hF9, 8);
    step(4'b1011, 8'hA4, 8);
    do_reset();
    fv0 = fv_cnt;
    step(4'b0111, 8'hB0, 8);
    check("midrst_fv", fv_cnt - fv0, 0);
    check("midrst_d3", bus.disp3, 8'h00);
    scan(8);
    check("midrst_full_fv", fv_cnt - fv0, 1);
    check("midrst_full_d3", bus.disp3, 8'h4F);

    // Glitch counter saturation; n samples are counted one edge after loading.
    do_reset();
    step(4'b0011, 8'hFF, 101);
    check("sat_100", bus.glitch_cnt, 8'd100);
    step(4'b0011, 8'hFF, 154);
    check("sat_254", bus.glitch_cnt, 8'd254);
    step(4'b0011, 8'hFF, 1);
    check("sat_255", bus.glitch_cnt, 8'd255);
    step(4'b0011, 8'hFF, 45);
    check("sat_hold", bus.glitch_cnt, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
